// File: rtl/ti_adc_capture.sv
// ============================================================================
// ti_adc_capture
// ----------------------------------------------------------------------------
// Downstream capture stage of the time-interleaved ADC. Each core clock it
// samples one frame (ADC_WAYS parallel sub-ADC words) and applies a per-way
// signed offset correction with saturation to the unsigned code range. An
// arm/stop FSM selects which frames are captured. Captured frames are buffered
// in a small FIFO and handed to the back-end over valid/ready.
//
// Ports
//   clk         core clock
//   rst_n       asynchronous active-low reset (aborts capture, empties FIFO)
//   adc_data    sub-ADC words, offset-binary; index 0 is the first way
//   cal_en      1: subtract cal_offset from each way
//   cal_offset  per-way two's-complement offset
//   arm         pulse: start a capture (also clears overflow/drop_cnt)
//   stop        pulse: end a capture
//   cont_mode   1: capture until stop; 0: capture cap_len frames
//   cap_len     single-shot capture length in frames
//   out_data    FIFO head frame (zero while the FIFO is empty)
//   out_valid   FIFO not empty
//   out_ready   consumer accepts the head frame
//   busy        FSM in RUN
//   done        FSM in DONE
//   overflow    sticky: a frame was dropped on a full FIFO
//   drop_cnt    number of dropped frames, saturating
// ============================================================================
module ti_adc_capture #(
    parameter int ADC_WAYS   = 8,
    parameter int ADC_BITS   = 9,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_BITS   = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [ADC_WAYS-1:0][ADC_BITS-1:0]  adc_data,
    input  logic                               cal_en,
    input  logic [ADC_WAYS-1:0][ADC_BITS-1:0]  cal_offset,
    input  logic                               arm,
    input  logic                               stop,
    input  logic                               cont_mode,
    input  logic [CNT_BITS-1:0]                cap_len,
    output logic [ADC_WAYS-1:0][ADC_BITS-1:0]  out_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               busy,
    output logic                               done,
    output logic                               overflow,
    output logic [CNT_BITS-1:0]                drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
    localparam logic [AW:0]         PTR_ONE = (AW+1)'(1);

    typedef logic [ADC_WAYS-1:0][ADC_BITS-1:0] frame_t;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    // Offset correction: widen to ADC_BITS+2 signed so adc - offset never
    // wraps, then clamp to the unsigned code range [0, 2^ADC_BITS-1].
    function automatic logic [ADC_BITS-1:0] sat_corr(
        input logic [ADC_BITS-1:0]        adc,
        input logic signed [ADC_BITS-1:0] off,
        input logic                       en
    );
        logic signed [ADC_BITS+1:0] diff;
        diff = $signed({2'b00, adc}) - $signed({{2{off[ADC_BITS-1]}}, off});
        if (!en)
            sat_corr = adc;
        else if (diff[ADC_BITS+1])
            sat_corr = '0;
        else if (diff[ADC_BITS])
            sat_corr = '1;
        else
            sat_corr = diff[ADC_BITS-1:0];
    endfunction

    // ------------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                zero_len;

    // Single-shot with cap_len==0 finishes on arm without tagging anything.
    assign zero_len = !cont_mode && (cap_len == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    cnt_d   = '0;
                    state_d = zero_len ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                // Every RUN edge tags one frame, including the stop edge.
                cnt_d = cnt_q + CNT_ONE;
                if (stop)
                    state_d = ST_IDLE;
                else if (!cont_mode && (cnt_q == cap_len - CNT_ONE))
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (arm) begin
                    cnt_d   = '0;
                    state_d = zero_len ? ST_DONE : ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

    // ------------------------------------------------------------------------
    // Stage 1: register raw frame and its calibration settings, tag if RUN
    // ------------------------------------------------------------------------
    frame_t adc_p1_q;
    frame_t off_p1_q;
    logic   cal_en_p1_q;
    logic   vld_p1_q;

    always_ff @(posedge clk) begin
        adc_p1_q    <= adc_data;
        off_p1_q    <= cal_offset;
        cal_en_p1_q <= cal_en;
    end

    // ------------------------------------------------------------------------
    // Stage 2: corrected and saturated frame
    // ------------------------------------------------------------------------
    frame_t corr_p2_d, corr_p2_q;
    logic   vld_p2_q;

    always_comb begin
        corr_p2_d = '0;
        for (int w = 0; w < ADC_WAYS; w++)
            corr_p2_d[w] = sat_corr(adc_p1_q[w], off_p1_q[w], cal_en_p1_q);
    end

    always_ff @(posedge clk) begin
        corr_p2_q <= corr_p2_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else begin
            vld_p1_q <= busy;
            vld_p2_q <= vld_p1_q;
        end
    end

    // ------------------------------------------------------------------------
    // Frame FIFO: pointers carry one extra wrap bit to tell full from empty
    // ------------------------------------------------------------------------
    frame_t        mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          fifo_empty, fifo_full;
    logic          pop, push, drop;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A full FIFO still accepts a frame when the head leaves in the same cycle.
    assign pop  = !fifo_empty && out_ready;
    assign push = vld_p2_q && (!fifo_full || pop);
    assign drop = vld_p2_q && fifo_full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push)
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)
            rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q[AW-1:0]] <= corr_p2_q;
    end

    // Storage is not reset, so the head is masked to zero while empty.
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // ------------------------------------------------------------------------
    // Overflow bookkeeping
    // ------------------------------------------------------------------------
    logic                overflow_q, overflow_d;
    logic [CNT_BITS-1:0] drop_cnt_q, drop_cnt_d;

    // arm wins over a simultaneous drop so a fresh capture starts clean.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (arm) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1)
                drop_cnt_d = drop_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule
